ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue capacity in 32-bit words; legal values are powers of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the first fetch address after reset.
REQ-003 Parameter LONG_BIT, default 0, SHALL select the bit of an instruction's first word that marks a 64-bit (two-word) instruction.
REQ-004 Parameter MAX_OUT, default 2, SHALL bound the number of outstanding bus reads.
REQ-005 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 Port bus, if_wb.master: pipelined Wishbone read-only master using cyc, stb, adr, sel, we, ack, stall and read data.
REQ-008 Port ir, output, 64: head instruction; first word in [63:32], second word in [31:0] (zero for short instructions).
REQ-009 Port pc, output, 32: address of the first word of ir.
REQ-010 Port valid, output, 1: ir and pc hold a complete instruction.
REQ-011 Port stall_i, input, 1: downstream not accepting.
REQ-012 Port halt, input, 1: stop issuing new bus reads.
REQ-013 Port pc_set, input, 1: redirect request.
REQ-014 Port pc_in, input, 32: redirect target, word-aligned.

Function
REQ-015 The block SHALL keep a fetch address fa, a DEPTH-entry word queue with head/tail pointers and a count, and an outstanding-read counter out.
REQ-016 The block SHALL assert stb with adr=fa, we=0 and sel=4'hf when !halt, out<MAX_OUT and count+out<DEPTH; fa SHALL advance by 4 on each cycle with stb && !stall.
REQ-017 cyc SHALL be high whenever stb is high or out>0.
REQ-018 Each ack SHALL decrement out and write the read data at tail, unless the ack belongs to a discarded read (REQ-023).
REQ-019 Head is long when word[LONG_BIT] of the head entry is 1; valid SHALL be 1 when count>=2, or when count==1 and head is short.
REQ-020 While valid==0, ir SHALL be 64'h0 (pipeline bubble) and pc SHALL hold its last value.
REQ-021 An instruction SHALL be consumed on a cycle with valid && !stall_i && !pc_set; head SHALL advance by 1 or 2 words and pc by 4 or 8.
REQ-022 Pointers SHALL wrap modulo DEPTH; the queue SHALL never overflow, because issue reserves space per REQ-016.
REQ-023 pc_set SHALL override every other input: clear the queue, set fa and pc to pc_in, and mark all reads outstanding that cycle as discarded, so their acks do not write the queue. New reads SHALL issue from the next cycle, after discarded reads drain (out==0).
REQ-024 pc_set together with ack on the same cycle SHALL discard that ack's data.
REQ-025 halt SHALL block only new issue; outstanding acks SHALL still be accepted and queue contents SHALL still be delivered.
REQ-026 Latency without bypass: a word acked into an empty queue SHALL make valid rise one cycle after the ack, for short instructions.
REQ-027 A long instruction whose second word has not arrived SHALL keep valid==0.

Reset
REQ-028 While rst_i==1 at a clock edge: queue empty, out=0, fa=pc=RESET_PC, cyc=stb=0, valid=0, ir=0.
REQ-029 Reset mid-transaction SHALL drop cyc in the following cycle; acks arriving after reset SHALL be ignored until the first new issue.

Configuration
REQ-030 When macro IFETCH_QUEUE_BYPASS_EN is defined, a short word acked while the queue is empty SHALL appear on ir and valid in the same cycle. If it is consumed that cycle it SHALL not be written to the queue.
REQ-031 Without IFETCH_QUEUE_BYPASS_EN, ir, pc and valid SHALL depend only on registered state.

Verification
REQ-032 Reset, zero-wait slave, memory word at addr n = n|0 (all short) -> reads at 0,4,8...; first valid with pc=0, ir=64'h00000000_00000000 is not a bubble case, so check ir[63:32]=0 and pc=0, then pc increments by 4 each cycle.
REQ-033 stall_i held high for 10 cycles, DEPTH=4 -> at most 4 words buffered, stb deasserts, no data loss; in-order delivery resumes after release.
REQ-034 Word at 0x10 = 32'h00000001 (long), word at 0x14 = 32'hCAFEBABE -> single valid with ir=64'h00000001_CAFEBABE, pc=0x10; next pc=0x18.
REQ-035 pc_set with pc_in=0x100 while 2 reads are outstanding; slave acks them 3 cycles later -> those words dropped; next valid has pc=0x100.
REQ-036 halt asserted with 1 read outstanding -> no new stb; the acked word is still delivered; pc_set at 0x40 while halted -> queue cleared, no issue until halt drops.
REQ-037 With IFETCH_QUEUE_BYPASS_EN defined, empty queue, ack of a short word at 0x20 -> valid=1 and pc=0x20 in the ack cycle; without the macro -> valid=1 one cycle later.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: pipelined Wishbone read master feeding a word queue that
// delivers 32/64-bit instructions. Define IFETCH_QUEUE_BYPASS_EN for same-cycle ack bypass.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned LONG_BIT = 0,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic [31:0] bus_adr,
  output logic [3:0]  bus_sel,
  output logic        bus_we,
  input  logic        bus_ack,
  input  logic        bus_stall,
  input  logic [31:0] bus_dat,
  output logic [63:0] ir,
  output logic [31:0] pc,
  output logic        valid,
  input  logic        stall_i,
  input  logic        halt,
  input  logic        pc_set,
  input  logic [31:0] pc_in
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned OUT_LIM = (MAX_OUT < DEPTH) ? MAX_OUT : DEPTH;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0] count, out, count_n, out_n, pop;
  logic [31:0]   fa, fa_n, pc_n;
  logic          flush, flush_n;

  logic [31:0]   head_word, next_word;
  logic          head_long, ack_ok, q_valid, byp, take, wr, issue;

  // Head decode, bus request and instruction presentation
  always_comb begin : decode
    head_word = mem[head];
    next_word = mem[head + PW'(1)];
    head_long = head_word[LONG_BIT];
    // acks with nothing outstanding are stale (e.g. from before a reset)
    ack_ok    = bus_ack && (out != '0);
    q_valid   = (count >= CW'(2)) || ((count == CW'(1)) && !head_long);
    byp       = BYPASS && (count == '0) && ack_ok && !flush && !pc_set && !rst_i &&
                !bus_dat[LONG_BIT];
    valid     = q_valid || byp;
    ir        = 64'h0;
    if (q_valid) begin
      ir = {head_word, head_long ? next_word : 32'h0};
    end else if (byp) begin
      ir = {bus_dat, 32'h0};
    end
    take      = valid && !stall_i && !pc_set;
    // a bypassed word consumed on arrival never occupies a slot
    wr        = ack_ok && !flush && !pc_set && !rst_i && !(byp && take);
    pop       = '0;
    if (take && q_valid) begin
      pop = head_long ? CW'(2) : CW'(1);
    end
    // count+out reserves a slot per read, so the queue cannot overflow
    bus_stb   = !rst_i && !pc_set && !halt && !flush &&
                (out < CW'(OUT_LIM)) && ((count + out) < CW'(DEPTH));
    issue     = bus_stb && !bus_stall;
    bus_cyc   = !rst_i && (bus_stb || (out != '0));
    bus_adr   = fa;
    bus_sel   = 4'hf;
    bus_we    = 1'b0;
  end

  // Next-state for pointers, counters and addresses
  always_comb begin : next_state
    out_n = out;
    if (issue) begin
      out_n = out_n + CW'(1);
    end
    if (ack_ok) begin
      out_n = out_n - CW'(1);
    end
    count_n = count - pop;
    if (wr) begin
      count_n = count_n + CW'(1);
    end
    head_n  = head + PW'(pop);
    tail_n  = wr ? tail + PW'(1) : tail;
    fa_n    = issue ? fa + 32'd4 : fa;
    pc_n    = pc;
    if (take) begin
      pc_n = pc + ((q_valid && head_long) ? 32'd8 : 32'd4);
    end
    flush_n = flush && (out_n != '0);
    // redirect: every read still in flight belongs to the old stream
    if (pc_set) begin
      count_n = '0;
      head_n  = '0;
      tail_n  = '0;
      fa_n    = pc_in;
      pc_n    = pc_in;
      flush_n = (out_n != '0);
    end
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      out   <= '0;
      fa    <= RESET_PC;
      pc    <= RESET_PC;
      flush <= 1'b0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      out   <= out_n;
      fa    <= fa_n;
      pc    <= pc_n;
      flush <= flush_n;
    end
  end

  always_ff @(posedge clk_i) begin : queue_mem
    if (wr) begin
      mem[tail] <= bus_dat;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: pipelined slave model with variable latency,
// program-order scoreboard of expected instructions, directed and random phases.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i, bus_cyc, bus_stb, bus_we, bus_ack, bus_stall, valid;
  logic        stall_i, halt, pc_set;
  logic [31:0] bus_adr, bus_dat, pc, pc_in;
  logic [3:0]  bus_sel;
  logic [63:0] ir;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .LONG_BIT(0), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_adr(bus_adr),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_ack(bus_ack), .bus_stall(bus_stall),
    .bus_dat(bus_dat), .ir(ir), .pc(pc), .valid(valid), .stall_i(stall_i), .halt(halt),
    .pc_set(pc_set), .pc_in(pc_in)
  );

  typedef struct packed { logic [31:0] pc; logic [63:0] ir; } instr_t;
  typedef struct packed { logic [31:0] adr; int due; } req_t;

  instr_t      exp_q[$];
  req_t        pend_q[$];
  int          cons_cyc [bit [31:0]];
  int          checks = 0, failures = 0;
  int          cyc_cnt = 0, n_cons = 0, iss_cnt = 0, lat = 1, bstall_pct = 0;
  int          ack_cyc_w = -1, val_cyc_w = -1, base;
  logic        t_rst, t_halt, t_stall, t_pcset, last_stb;
  logic [31:0] t_pcin, tb_fa, watch_adr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0000_0001;
      32'h14:  return 32'hCAFE_BABE;
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Program-order instruction stream starting at a fetch target
  task automatic load_expected(input logic [31:0] start);
    logic [31:0] a, w;
    instr_t e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 512; i++) begin
      w = mem_word(a);
      e.pc = a;
      if (w[0]) begin
        e.ir = {w, mem_word(a + 32'd4)};
        a += 32'd8;
      end else begin
        e.ir = {w, 32'h0};
        a += 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive at negedge, sample #1 later (values seen by the next posedge)
  task automatic step();
    req_t   r;
    instr_t e;
    @(negedge clk);
    cyc_cnt++;
    rst_i     = t_rst;
    halt      = t_halt;
    stall_i   = t_stall;
    pc_set    = t_pcset;
    pc_in     = t_pcin;
    bus_stall = (int'($urandom_range(99)) < bstall_pct);
    bus_ack   = 1'b0;
    bus_dat   = 32'h0;
    if (t_rst) begin
      load_expected(RESET_PC);
      tb_fa = RESET_PC;
    end else if (t_pcset) begin
      load_expected(t_pcin);
      tb_fa = t_pcin;
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc_cnt) begin
      r       = pend_q.pop_front();
      bus_ack = 1'b1;
      bus_dat = mem_word(r.adr);
      if (r.adr == watch_adr && ack_cyc_w < 0) ack_cyc_w = cyc_cnt;
    end
    #1;
    last_stb = bus_stb;
    if (!t_rst) begin
      if (pc_set) check("stb_on_pc_set", 64'(bus_stb), 64'(0));
      if (bus_stb && !bus_stall) begin
        check("issue_adr", 64'(bus_adr), 64'(tb_fa));
        check("issue_we_sel", 64'({bus_we, bus_sel}), 64'(5'h0f));
        tb_fa += 32'd4;
        r.adr = bus_adr;
        r.due = cyc_cnt + lat;
        pend_q.push_back(r);
        iss_cnt++;
        check("out_bound", 64'(pend_q.size() <= MAX_OUT), 64'(1));
      end
      if (valid === 1'b1) begin
        if (val_cyc_w < 0 && pc == watch_adr) val_cyc_w = cyc_cnt;
        if (!stall_i && !pc_set) begin
          if (exp_q.size() == 0) begin
            check("exp_empty", 64'(0), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("cons_pc", 64'(pc), 64'(e.pc));
            check("cons_ir", ir, e.ir);
          end
          cons_cyc[pc] = cyc_cnt;
          n_cons++;
        end
      end else begin
        check("bubble_ir", ir, 64'h0);
      end
    end
  endtask

  task automatic run_cons(input int n);
    int target;
    target = n_cons + n;
    for (int i = 0; i < 300 && n_cons < target; i++) step();
    check("cons_progress", 64'(n_cons >= target), 64'(1));
  endtask

  task automatic wait_pending(input int n);
    for (int i = 0; i < 40 && pend_q.size() != n; i++) step();
    check("wait_pending", 64'(pend_q.size()), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cycles=%0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; halt = 1'b0; stall_i = 1'b0; pc_set = 1'b0; pc_in = 32'h0;
    bus_ack = 1'b0; bus_stall = 1'b0; bus_dat = 32'h0;
    t_rst = 1'b1; t_halt = 1'b0; t_stall = 1'b0; t_pcset = 1'b0; t_pcin = 32'h0;
    tb_fa = RESET_PC; watch_adr = 32'hFFFF_FFFF; last_stb = 1'b0;

    // reset state
    step(); step();
    check("rst_cyc", 64'(bus_cyc), 64'(0));
    check("rst_stb", 64'(bus_stb), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_ir", ir, 64'h0);
    check("rst_pc", 64'(pc), 64'(RESET_PC));
    t_rst = 1'b0;

    // zero-wait stream, including the long instruction at 0x10
    cons_cyc.delete();
    run_cons(12);
    check("stream_gap", 64'(cons_cyc.exists(32'hC) && cons_cyc.exists(32'h0) ?
          cons_cyc[32'hC] - cons_cyc[32'h0] : -1), 64'(3));
    check("long_at_10", 64'(cons_cyc.exists(32'h10)), 64'(1));
    check("no_split_14", 64'(cons_cyc.exists(32'h14)), 64'(0));
    check("after_long_18", 64'(cons_cyc.exists(32'h18)), 64'(1));

    // downstream stall fills the queue and stops issue
    t_stall = 1'b1; iss_cnt = 0;
    repeat (10) step();
    check("stall_stb_low", 64'(last_stb), 64'(0));
    check("stall_buffered", 64'(iss_cnt <= DEPTH), 64'(1));
    t_stall = 1'b0;
    run_cons(8);

    // redirect with two slow reads in flight
    lat = 3;
    wait_pending(2);
    t_pcset = 1'b1; t_pcin = 32'h100;
    step();
    t_pcset = 1'b0;
    cons_cyc.delete();
    run_cons(6);
    check("redirect_100", 64'(cons_cyc.exists(32'h100)), 64'(1));

    // halt with one read outstanding, then redirect while halted
    t_halt = 1'b1; t_pcset = 1'b1; t_pcin = 32'h200;
    step();
    t_pcset = 1'b0;
    wait_pending(0);
    t_stall = 1'b1; t_halt = 1'b0;
    step();
    check("halt_one_out", 64'(pend_q.size()), 64'(1));
    t_halt = 1'b1;
    repeat (8) begin
      step();
      check("halt_no_stb", 64'(last_stb), 64'(0));
    end
    check("halt_delivered_valid", 64'(valid), 64'(1));
    check("halt_delivered_pc", 64'(pc), 64'(32'h200));
    check("halt_delivered_ir", ir, {32'h200, 32'h0});
    t_pcset = 1'b1; t_pcin = 32'h40; t_stall = 1'b0;
    step();
    t_pcset = 1'b0;
    repeat (4) begin
      step();
      check("halt_no_stb2", 64'(last_stb), 64'(0));
      check("halt_cleared", 64'(valid), 64'(0));
    end
    t_halt = 1'b0;
    cons_cyc.delete();
    run_cons(4);
    check("halt_redirect_40", 64'(cons_cyc.exists(32'h40)), 64'(1));

    // ack-to-valid latency into an empty queue
    t_halt = 1'b1; lat = 1; t_pcset = 1'b1; t_pcin = 32'h20;
    step();
    t_pcset = 1'b0;
    wait_pending(0);
    step();
    watch_adr = 32'h20; ack_cyc_w = -1; val_cyc_w = -1;
    t_halt = 1'b0;
    run_cons(3);
    check("ack_to_valid", 64'((ack_cyc_w >= 0 && val_cyc_w >= 0) ? val_cyc_w - ack_cyc_w : -1),
          64'(EXP_LAT));
    watch_adr = 32'hFFFF_FFFF;

    // reset mid-transaction; stale acks must be ignored
    lat = 3;
    wait_pending(2);
    t_rst = 1'b1; t_halt = 1'b1;
    step();
    t_rst = 1'b0;
    step();
    check("rst_mid_cyc", 64'(bus_cyc), 64'(0));
    repeat (6) begin
      step();
      check("rst_stale_valid", 64'(valid), 64'(0));
    end
    check("rst_stale_drained", 64'(pend_q.size()), 64'(0));
    t_halt = 1'b0;
    cons_cyc.delete();
    run_cons(4);
    check("rst_restart_0", 64'(cons_cyc.exists(32'h0)), 64'(1));

    // random mix of stalls, halts, redirects and slave latency
    bstall_pct = 25;
    base = n_cons;
    repeat (400) begin
      lat     = int'($urandom_range(3, 1));
      t_stall = ($urandom_range(99) < 30);
      t_halt  = ($urandom_range(99) < 10);
      t_pcset = ($urandom_range(99) < 3);
      t_pcin  = 32'($urandom_range(63)) << 2;
      step();
    end
    check("rand_progress", 64'((n_cons - base) > 40), 64'(1));
    t_stall = 1'b0; t_halt = 1'b0; t_pcset = 1'b0; bstall_pct = 0;
    run_cons(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
